prio_encoder_arb: RTL and testbench
===================================

// Module: prio_encoder_arb
// PURPOSE
//  Parametrised, registered priority encoder and arbiter. It encodes N request lines into a binary
//  index plus a one-hot grant. Priority is fixed (lowest index wins) or round-robin, and each result
//  is held under a valid/ready handshake until the consumer accepts it. Sits between request
//  sources and a single shared consumer; replaces the 4-input combinational encoder.
// PARAMETERS
//  N        4   number of request lines, N >= 1
//  RR_MODE  0   0 = fixed priority (index 0 highest); 1 = round-robin
//  W        derived localparam = (N>1) ? $clog2(N) : 1; width of out_idx
// PORTS
//  clk         in   1    rising-edge clock
//  rst         in   1    asynchronous, active-high reset
//  req         in   N    request lines; bit i = requester i
//  out_ready   in   1    consumer accepts the current result
//  out_valid   out  1    a grant is presented on out_idx/out_onehot
//  out_idx     out  W    binary index of the granted requester
//  out_onehot  out  N    one-hot form of out_idx; all zero when out_valid=0
//  busy        out  1    =1 while state is HOLD (equals out_valid)
// BEHAVIOUR
//  Reset (async, any time, incl. mid-HOLD):
//   - out_valid=0, out_idx=0, out_onehot=0, ptr=0, state=IDLE.
//   - A pending grant is dropped and nothing is replayed after reset.
//  Registers: state {IDLE, HOLD}, ptr[W-1:0], out_idx, out_onehot, out_valid. All outputs are registered.
//  Arbitration (combinational, from req and a start index s):
//   - RR_MODE=0: s = 0 always.
//   - RR_MODE=1: s = (state==HOLD && accept) ? (out_idx+1 mod N) : ptr.
//   - Winner = first i with req[i]=1, scanning s, s+1, ..., N-1, 0, ..., s-1.
//   - any_req = |req.
//  accept = out_valid & out_ready.
//  IDLE:
//   - any_req=1: load winner into out_idx/out_onehot, out_valid<=1, go to HOLD.
//   - Latency is 1 clk from req sampled to out_valid high.
//   - any_req=0: stay in IDLE; outputs unchanged (out_valid=0, out_onehot=0).
//  HOLD:
//   - out_idx/out_onehot stay stable until accept, even if the granted req bit drops (no retraction).
//   - accept & any_req: load the new winner the same edge and stay in HOLD. Back-to-back grants,
//     one per clk, are allowed.
//   - accept & !any_req: out_valid<=0, out_onehot<=0, go to IDLE. out_idx keeps its last value.
//   - !accept: hold everything.
//  ptr (RR_MODE=1 only):
//   - On accept, ptr <= out_idx+1; wraps N-1 -> 0.
//   - ptr never changes without an accept.
//   - With RR_MODE=0, ptr stays 0.
//  Boundaries:
//   - N=1: out_idx is always 0; ptr wrap is 0->0.
//   - All req high: fixed mode always grants 0; RR grants 0,1,...,N-1,0,...
//   - out_ready high while out_valid=0: ignored.
//   - Requests arriving during HOLD are not latched; they are evaluated live at the next arbitration.
//  Outputs are never X after reset. No latches: every register is assigned on every path.
// TESTING
//  T1 reset: assert rst mid-HOLD (N=4) -> out_valid=0, out_onehot=0, out_idx=0 asynchronously,
//     before the next clk edge.
//  T2 fixed: RR_MODE=0, req=4'b1010, out_ready=1 -> out_idx=1, onehot=0010 every cycle, 1 clk
//     after req applied.
//  T3 RR: RR_MODE=1, req=4'b1111, out_ready=1 for 6 clk -> out_idx sequence 0,1,2,3,0,1,
//     out_valid constantly 1.
//  T4 stall: req=4'b0100, out_ready=0 for 5 clk, then req=0 -> out_idx=2, valid held all 5+ clk;
//     out_ready=1 -> valid=0 next clk.
//  T5 wrap/skip: RR_MODE=1, N=4, ptr=3 after a grant to idx 2, req=4'b0001 -> grant idx 0;
//     next req=4'b1001 -> grant idx 3.
//  T6 N=1 and N=5: req toggling, out_ready random -> scoreboard matches the reference arbitration
//     model; no X on outputs.

Source files
------------

// File: rtl/prio_encoder_arb.sv
// Registered priority encoder / arbiter with fixed or round-robin priority.
// Each grant is held under a valid/ready handshake until the consumer accepts it.
module prio_encoder_arb #(
    parameter int N       = 4,
    parameter int RR_MODE = 0,
    localparam int W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    state_t         state_r;
    state_t         state_n;
    logic [W-1:0]   ptr_r;
    logic [W-1:0]   ptr_n;
    logic [W-1:0]   idx_n;
    logic [N-1:0]   onehot_n;
    logic           valid_n;

    logic           accept_s;
    logic           any_req_s;
    logic [W-1:0]   inc_idx_s;
    logic [W-1:0]   start_s;
    logic [N-1:0]   rot_s;
    logic [N-1:0]   iso_s;
    logic [N-1:0]   win_onehot_s;
    logic [W-1:0]   win_idx_s;

    assign accept_s  = out_valid & out_ready;
    assign any_req_s = |req;
    assign inc_idx_s = (out_idx == LAST_IDX) ? {W{1'b0}} : out_idx + W'(1);

    // Start index for the scan: the slot after an accepted grant takes effect on the same edge.
    always_comb begin
        start_s = {W{1'b0}};
        if (RR_MODE == 0) begin
            start_s = {W{1'b0}};
        end else if ((state_r == HOLD) && accept_s) begin
            start_s = inc_idx_s;
        end else begin
            start_s = ptr_r;
        end
    end

    // Winner search: rotate requests so the start slot sits at bit 0, isolate the lowest set bit,
    // then rotate back to absolute position.
    always_comb begin
        rot_s        = N'({req, req} >> start_s);
        iso_s        = rot_s & ~(rot_s - N'(1));
        win_onehot_s = N'(({iso_s, iso_s} << start_s) >> N);
        win_idx_s    = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (win_onehot_s[i]) begin
                win_idx_s = win_idx_s | W'(i);
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/HOLD handshake machine.
    always_comb begin
        state_n  = state_r;
        ptr_n    = ptr_r;
        idx_n    = out_idx;
        onehot_n = out_onehot;
        valid_n  = out_valid;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    idx_n    = win_idx_s;
                    onehot_n = win_onehot_s;
                    valid_n  = 1'b1;
                    state_n  = HOLD;
                end else begin
                    valid_n  = 1'b0;
                    onehot_n = {N{1'b0}};
                end
            end
            HOLD: begin
                if (accept_s) begin
                    if (RR_MODE != 0) begin
                        ptr_n = inc_idx_s;
                    end else begin
                        ptr_n = {W{1'b0}};
                    end
                    // A granted line that drops before accept is never retracted; only accept moves on.
                    if (any_req_s) begin
                        idx_n    = win_idx_s;
                        onehot_n = win_onehot_s;
                        valid_n  = 1'b1;
                        state_n  = HOLD;
                    end else begin
                        onehot_n = {N{1'b0}};
                        valid_n  = 1'b0;
                        state_n  = IDLE;
                    end
                end else begin
                    state_n = HOLD;
                end
            end
            default: begin
                state_n  = IDLE;
                ptr_n    = {W{1'b0}};
                idx_n    = {W{1'b0}};
                onehot_n = {N{1'b0}};
                valid_n  = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= {W{1'b0}};
            out_idx    <= {W{1'b0}};
            out_onehot <= {N{1'b0}};
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_n;
            ptr_r      <= ptr_n;
            out_idx    <= idx_n;
            out_onehot <= onehot_n;
            out_valid  <= valid_n;
            busy       <= valid_n;
        end
    end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Scoreboard bench for prio_encoder_arb: four instances (N=4 fixed, N=4 RR, N=1 RR, N=5 RR)
// checked each cycle against an independent arbitration model, plus directed scenario checks.
module tb_prio_encoder_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req_a, req_b;
    logic [0:0] req_c;
    logic [4:0] req_d;
    logic       rdy_a, rdy_b, rdy_c, rdy_d;
    logic       val_a, val_b, val_c, val_d;
    logic       bsy_a, bsy_b, bsy_c, bsy_d;
    logic [1:0] idx_a, idx_b;
    logic [0:0] idx_c;
    logic [2:0] idx_d;
    logic [3:0] oh_a, oh_b;
    logic [0:0] oh_c;
    logic [4:0] oh_d;

    prio_encoder_arb #(.N(4), .RR_MODE(0)) u_a (.clk(clk), .rst(rst), .req(req_a), .out_ready(rdy_a),
        .out_valid(val_a), .out_idx(idx_a), .out_onehot(oh_a), .busy(bsy_a));
    prio_encoder_arb #(.N(4), .RR_MODE(1)) u_b (.clk(clk), .rst(rst), .req(req_b), .out_ready(rdy_b),
        .out_valid(val_b), .out_idx(idx_b), .out_onehot(oh_b), .busy(bsy_b));
    prio_encoder_arb #(.N(1), .RR_MODE(1)) u_c (.clk(clk), .rst(rst), .req(req_c), .out_ready(rdy_c),
        .out_valid(val_c), .out_idx(idx_c), .out_onehot(oh_c), .busy(bsy_c));
    prio_encoder_arb #(.N(5), .RR_MODE(1)) u_d (.clk(clk), .rst(rst), .req(req_d), .out_ready(rdy_d),
        .out_valid(val_d), .out_idx(idx_d), .out_onehot(oh_d), .busy(bsy_d));

    typedef struct {
        int inst;
        bit valid;
        int idx;
        int onehot;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   n_of[4]  = '{4, 4, 1, 5};
    int   rr_of[4] = '{0, 1, 1, 1};
    bit   m_valid[4];
    int   m_idx[4];
    int   m_ptr[4];

    function automatic int get_req(input int k);
        case (k)
            0: return int'(req_a);
            1: return int'(req_b);
            2: return int'(req_c);
            3: return int'(req_d);
            default: return 0;
        endcase
    endfunction

    function automatic bit get_rdy(input int k);
        case (k)
            0: return rdy_a;
            1: return rdy_b;
            2: return rdy_c;
            3: return rdy_d;
            default: return 1'b0;
        endcase
    endfunction

    task automatic get_out(input int k, output bit v, output int idx, output int oh, output bit bz, output bit xs);
        case (k)
            0: begin v = val_a; idx = int'(idx_a); oh = int'(oh_a); bz = bsy_a; xs = $isunknown({val_a, idx_a, oh_a, bsy_a}); end
            1: begin v = val_b; idx = int'(idx_b); oh = int'(oh_b); bz = bsy_b; xs = $isunknown({val_b, idx_b, oh_b, bsy_b}); end
            2: begin v = val_c; idx = int'(idx_c); oh = int'(oh_c); bz = bsy_c; xs = $isunknown({val_c, idx_c, oh_c, bsy_c}); end
            default: begin v = val_d; idx = int'(idx_d); oh = int'(oh_d); bz = bsy_d; xs = $isunknown({val_d, idx_d, oh_d, bsy_d}); end
        endcase
    endtask

    // Reference scan: first requester at or after s, wrapping modulo n.
    function automatic int ref_winner(input int n, input int s, input int rq);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (s + k) % n;
            if (rq[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 1'b0;
            m_idx[k]   = 0;
            m_ptr[k]   = 0;
        end
        exp_q.delete();
    endtask

    // Predict every instance for the coming edge, clock once, then compare at the falling edge.
    task automatic tick();
        exp_t e;
        bit   v, bz, xs;
        int   idx, oh;
        for (int k = 0; k < 4; k++) begin
            int  rq;
            bit  acc;
            rq  = get_req(k);
            acc = m_valid[k] && get_rdy(k);
            if (acc && rr_of[k] != 0) m_ptr[k] = (m_idx[k] + 1) % n_of[k];
            if (!m_valid[k] || acc) begin
                if (rq != 0) begin
                    m_valid[k] = 1'b1;
                    m_idx[k]   = ref_winner(n_of[k], (rr_of[k] != 0) ? m_ptr[k] : 0, rq);
                end else begin
                    m_valid[k] = 1'b0;
                end
            end
            e.inst   = k;
            e.valid  = m_valid[k];
            e.idx    = m_idx[k];
            e.onehot = m_valid[k] ? (1 << m_idx[k]) : 0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_out(e.inst, v, idx, oh, bz, xs);
            tests_run++;
            if (xs || v !== e.valid || idx !== e.idx || oh !== e.onehot || bz !== e.valid) begin
                tests_failed++;
                $display("FAIL scoreboard inst%0d t=%0t: got v=%0b idx=%0d oh=%0h busy=%0b x=%0b, want v=%0b idx=%0d oh=%0h",
                         e.inst, $time, v, idx, oh, bz, xs, e.valid, e.idx, e.onehot);
            end
        end
    endtask

    task automatic test_reset();
        bit v, bz, xs;
        int idx, oh;
        #1;
        for (int k = 0; k < 4; k++) begin
            get_out(k, v, idx, oh, bz, xs);
            tests_run++;
            if (xs || v !== 1'b0 || idx !== 0 || oh !== 0 || bz !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_state inst%0d: got v=%0b idx=%0d oh=%0h x=%0b, want all zero", k, v, idx, oh, xs);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_fixed();
        req_a = 4'b1010;
        rdy_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (val_a !== 1'b1 || idx_a !== 2'd1 || oh_a !== 4'b0010) begin
                tests_failed++;
                $display("FAIL fixed cyc%0d: got v=%0b idx=%0d oh=%b, want v=1 idx=1 oh=0010", i, val_a, idx_a, oh_a);
            end
        end
        req_a = 4'b0000;
        tick();
    endtask

    task automatic test_rr();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        req_b = 4'b1111;
        rdy_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (val_b !== 1'b1 || int'(idx_b) !== seq[i]) begin
                tests_failed++;
                $display("FAIL rr_seq cyc%0d: got v=%0b idx=%0d, want v=1 idx=%0d", i, val_b, idx_b, seq[i]);
            end
        end
        req_b = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        logic [3:0] reqs[3] = '{4'b0100, 4'b0001, 4'b1001};
        int         want[3] = '{2, 0, 3};
        rdy_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_b = reqs[i];
            tick();
            tests_run++;
            if (val_b !== 1'b1 || int'(idx_b) !== want[i]) begin
                tests_failed++;
                $display("FAIL rr_wrap step%0d: got v=%0b idx=%0d, want v=1 idx=%0d", i, val_b, idx_b, want[i]);
            end
        end
        req_b = 4'b0000;
        tick();
    endtask

    task automatic test_stall();
        req_a = 4'b0100;
        rdy_a = 1'b0;
        tick();
        req_a = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (val_a !== 1'b1 || idx_a !== 2'd2 || oh_a !== 4'b0100) begin
                tests_failed++;
                $display("FAIL stall_hold cyc%0d: got v=%0b idx=%0d oh=%b, want v=1 idx=2 oh=0100", i, val_a, idx_a, oh_a);
            end
            tick();
        end
        rdy_a = 1'b1;
        tick();
        tests_run++;
        if (val_a !== 1'b0 || oh_a !== 4'b0000 || idx_a !== 2'd2) begin
            tests_failed++;
            $display("FAIL stall_release: got v=%0b idx=%0d oh=%b, want v=0 idx=2 oh=0000", val_a, idx_a, oh_a);
        end
        rdy_a = 1'b0;
    endtask

    task automatic test_async_reset();
        req_a = 4'b0001;
        rdy_a = 1'b0;
        req_b = 4'b0010;
        rdy_b = 1'b1;
        tick();
        tick();
        rdy_b = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (val_a !== 1'b0 || idx_a !== 2'd0 || oh_a !== 4'b0000 || val_b !== 1'b0 || oh_b !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_reset: got a(v=%0b idx=%0d oh=%b) b(v=%0b oh=%b), want all zero",
                     val_a, idx_a, oh_a, val_b, oh_b);
        end
        @(posedge clk);
        @(negedge clk);
        req_a = 4'b0000;
        req_b = 4'b1111;
        rdy_b = 1'b1;
        rst   = 1'b0;
        model_reset();
        tick();
        tests_run++;
        if (val_a !== 1'b0 || val_b !== 1'b1 || idx_b !== 2'd0) begin
            tests_failed++;
            $display("FAIL post_reset: got a.v=%0b b.v=%0b b.idx=%0d, want a.v=0 b.v=1 b.idx=0", val_a, val_b, idx_b);
        end
        req_b = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 < 5) begin
                req_a = 4'hF; req_b = 4'hF; req_c = 1'b1; req_d = 5'h1F;
            end else begin
                req_a = 4'($urandom_range(0, 15));
                req_b = 4'($urandom_range(0, 15));
                req_c = 1'($urandom_range(0, 1));
                req_d = 5'($urandom_range(0, 31));
            end
            rdy_a = ($urandom_range(0, 9) < 6);
            rdy_b = ($urandom_range(0, 9) < 6);
            rdy_c = ($urandom_range(0, 9) < 6);
            rdy_d = ($urandom_range(0, 9) < 6);
            tick();
            tests_run++;
            if ($isunknown({val_a, idx_a, oh_a, val_b, idx_b, oh_b, val_c, idx_c, oh_c, val_d, idx_d, oh_d})) begin
                tests_failed++;
                $display("FAIL no_x cyc%0d: got X on an output, want none", i);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        req_a = 4'b0000; req_b = 4'b0000; req_c = 1'b0; req_d = 5'b00000;
        rdy_a = 1'b0;    rdy_b = 1'b0;    rdy_c = 1'b0; rdy_d = 1'b0;
        model_reset();
        test_reset();
        test_fixed();
        test_rr();
        test_wrap();
        test_stall();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
